// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: array geometry and FSM state encoding.
package systolic_feeder_pkg;

    localparam int unsigned ARRAY_DIM    = 4;
    localparam int unsigned NUM_ELEMS    = ARRAY_DIM * ARRAY_DIM;
    localparam int unsigned STREAM_BEATS = 2 * ARRAY_DIM - 1;
    localparam int unsigned DIM_W        = $clog2(ARRAY_DIM);
    localparam int unsigned ELEM_W       = $clog2(NUM_ELEMS);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } feeder_state_e;

endpackage

// File: rtl/feeder_skew_mux.sv
// Combinational diagonal skew: maps a beat index onto the four row (left) and four
// column (up) operands of the 4x4 array; positions outside the diagonal band read 0.
module feeder_skew_mux
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]                                beat_i,
    input  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0]      a_i,
    input  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0]      b_i,
    output logic [ARRAY_DIM-1:0][DATA_WIDTH-1:0]      left_o,
    output logic [ARRAY_DIM-1:0][DATA_WIDTH-1:0]      up_o
);

    // Row r carries A[r][t-r]; column c carries B[t-c][c].
    always_comb begin
        left_o = '0;
        up_o   = '0;
        for (int r = 0; r < int'(ARRAY_DIM); r++) begin
            for (int k = 0; k < int'(ARRAY_DIM); k++) begin
                if (beat_i == 3'(r + k)) begin
                    left_o[DIM_W'(r)] = a_i[ELEM_W'(r * int'(ARRAY_DIM) + k)];
                    up_o[DIM_W'(r)]   = b_i[ELEM_W'(k * int'(ARRAY_DIM) + r)];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 systolic array: buffers A/B, streams them with diagonal skew,
// drains with zeros, then pulses done. FEEDER_DBLBUF_EN adds a second A/B bank.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic                  wr_sel_i,
    input  logic [3:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] left_o_0,
    output logic [DATA_WIDTH-1:0] left_o_4,
    output logic [DATA_WIDTH-1:0] left_o_8,
    output logic [DATA_WIDTH-1:0] left_o_12,
    output logic [DATA_WIDTH-1:0] up_o_0,
    output logic [DATA_WIDTH-1:0] up_o_1,
    output logic [DATA_WIDTH-1:0] up_o_2,
    output logic [DATA_WIDTH-1:0] up_o_3,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned       DrainW    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);
    localparam logic [2:0]        BeatLast  = 3'(STREAM_BEATS - 1);

    typedef logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] mat_t;

    feeder_state_e r_state, w_state_nxt;
    logic [2:0]        r_beat, w_beat_nxt;
    logic [DrainW-1:0] r_drain, w_drain_nxt;
    logic              w_start;
    mat_t              w_a_rd, w_b_rd;
    logic [ARRAY_DIM-1:0][DATA_WIDTH-1:0] r_left, r_up, w_left_sk, w_up_sk;

    assign w_start = start_i && (r_state == StIdle);

`ifdef FEEDER_DBLBUF_EN
    mat_t r_a [2];
    mat_t r_b [2];
    mat_t w_a_nxt [2];
    mat_t w_b_nxt [2];
    logic r_bank, w_bank_nxt;

    assign w_bank_nxt = r_bank ^ w_start;

    // Writes always land in the idle bank; start flips it into service.
    always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        if (wr_en_i) begin
            if (wr_sel_i) w_b_nxt[~r_bank][wr_addr_i] = wr_data_i;
            else          w_a_nxt[~r_bank][wr_addr_i] = wr_data_i;
        end
    end

    assign w_a_rd = w_a_nxt[w_bank_nxt];
    assign w_b_rd = w_b_nxt[w_bank_nxt];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a    <= '{default: '0};
            r_b    <= '{default: '0};
            r_bank <= 1'b0;
        end else begin
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_bank <= w_bank_nxt;
        end
    end
`else
    mat_t r_a, r_b, w_a_nxt, w_b_nxt;
    logic w_wr_ok;

    assign w_wr_ok = wr_en_i && ((r_state == StIdle) || (r_state == StDone));

    always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        if (w_wr_ok) begin
            if (wr_sel_i) w_b_nxt[wr_addr_i] = wr_data_i;
            else          w_a_nxt[wr_addr_i] = wr_data_i;
        end
    end

    // Reading the post-write view lets a same-cycle write reach beat 0.
    assign w_a_rd = w_a_nxt;
    assign w_b_rd = w_b_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= w_a_nxt;
            r_b <= w_b_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_drain_nxt = r_drain;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_nxt = StStream;
                    w_beat_nxt  = '0;
                end
            end
            StStream: begin
                if (r_beat == BeatLast) begin
                    w_state_nxt = StDrain;
                    w_drain_nxt = '0;
                end else begin
                    w_beat_nxt = r_beat + 3'd1;
                end
            end
            StDrain: begin
                if (r_drain == DrainLast) w_state_nxt = StDone;
                else                      w_drain_nxt = r_drain + DrainW'(1);
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    feeder_skew_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
        .beat_i (w_beat_nxt),
        .a_i    (w_a_rd),
        .b_i    (w_b_rd),
        .left_o (w_left_sk),
        .up_o   (w_up_sk)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_beat  <= '0;
            r_drain <= '0;
            r_left  <= '0;
            r_up    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_drain <= w_drain_nxt;
            r_left  <= (w_state_nxt == StStream) ? w_left_sk : '0;
            r_up    <= (w_state_nxt == StStream) ? w_up_sk : '0;
        end
    end

    assign left_o_0  = r_left[0];
    assign left_o_4  = r_left[1];
    assign left_o_8  = r_left[2];
    assign left_o_12 = r_left[3];
    assign up_o_0    = r_up[0];
    assign up_o_1    = r_up[1];
    assign up_o_2    = r_up[2];
    assign up_o_3    = r_up[3];
    assign busy_o    = (r_state == StStream) || (r_state == StDrain);
    assign done_o    = (r_state == StDone);

endmodule
